// File: rtl/multicycle_cpu_core.sv
// Multicycle FETCH/DECODE/EXEC/WB CPU core with parametrised datapath and register file.
// Latency 4 cycles/instruction plus one per imem wait cycle; FETCH stalls until imem_valid.
module multicycle_cpu_core #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [15:0]       imem_data,
    output logic [PC_W-1:0]   pc_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        flags,
    output logic              halted,
    output logic              illegal,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, npc_q, npc_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, wb_q, wb_d;
    logic [3:0]        flags_q, flags_d;
    logic              illegal_q, illegal_d;
    logic              reg_we;
    logic [DATA_W-1:0] regs_q [8];

    logic [3:0] op;
    logic [2:0] rd, rs1, rs2;
    assign op  = ir_q[15:12];
    assign rd  = ir_q[11:9];
    assign rs1 = ir_q[8:6];
    assign rs2 = ir_q[5:3];

    // Immediate widened with zeros, then cut to the destination width.
    logic [DATA_W+7:0] imm_data_ext;
    logic [PC_W+7:0]   imm_pc_ext;
    logic [DATA_W-1:0] imm_data;
    logic [PC_W-1:0]   imm_pc;
    assign imm_data_ext = {{DATA_W{1'b0}}, ir_q[7:0]};
    assign imm_pc_ext   = {{PC_W{1'b0}}, ir_q[7:0]};
    assign imm_data     = imm_data_ext[DATA_W-1:0];
    assign imm_pc       = imm_pc_ext[PC_W-1:0];

    logic [DATA_W-1:0] rs1_val, rs2_val;
    assign rs1_val  = (32'(rs1) < NREGS) ? regs_q[rs1] : '0;
    assign rs2_val  = (32'(rs2) < NREGS) ? regs_q[rs2] : '0;
    assign dbg_data = (32'(dbg_addr) < NREGS) ? regs_q[dbg_addr] : '0;

    logic [DATA_W:0]   add_full, sub_full;
    logic [DATA_W-1:0] add_res, sub_res, and_res, or_res, xor_res;
    logic              add_ovf, sub_ovf;
    assign add_full = {1'b0, a_q} + {1'b0, b_q};
    assign sub_full = {1'b0, a_q} - {1'b0, b_q};
    assign add_res  = add_full[DATA_W-1:0];
    assign sub_res  = sub_full[DATA_W-1:0];
    assign and_res  = a_q & b_q;
    assign or_res   = a_q | b_q;
    assign xor_res  = a_q ^ b_q;
    assign add_ovf  = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (add_res[DATA_W-1] != a_q[DATA_W-1]);
    assign sub_ovf  = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (sub_res[DATA_W-1] != a_q[DATA_W-1]);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        npc_d     = npc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        wb_d      = wb_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        reg_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rs1_val;
                b_d     = rs2_val;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                npc_d   = pc_q + PC_W'(1);
                case (op)
                    4'h0: ;
                    4'h1: begin
                        alu_d   = add_res;
                        wb_d    = add_res;
                        flags_d = {add_ovf, add_res[DATA_W-1], add_res == '0, add_full[DATA_W]};
                    end
                    4'h2, 4'hA: begin
                        alu_d   = sub_res;
                        wb_d    = sub_res;
                        flags_d = {sub_ovf, sub_res[DATA_W-1], sub_res == '0, sub_full[DATA_W]};
                    end
                    4'h3: begin
                        alu_d   = and_res;
                        wb_d    = and_res;
                        flags_d = {1'b0, and_res[DATA_W-1], and_res == '0, 1'b0};
                    end
                    4'h4: begin
                        alu_d   = or_res;
                        wb_d    = or_res;
                        flags_d = {1'b0, or_res[DATA_W-1], or_res == '0, 1'b0};
                    end
                    4'h5: begin
                        alu_d   = xor_res;
                        wb_d    = xor_res;
                        flags_d = {1'b0, xor_res[DATA_W-1], xor_res == '0, 1'b0};
                    end
                    4'h6: wb_d = imm_data;
                    4'h7: wb_d = a_q;
                    4'h8: npc_d = imm_pc;
                    4'h9: if (flags_q[1]) npc_d = imm_pc;
                    4'hF: npc_d = pc_q;  // HLT leaves pc pointing at itself
                    default: illegal_d = 1'b1;
                endcase
            end
            S_WB: begin
                reg_we  = (op >= 4'h1) && (op <= 4'h7);
                pc_d    = npc_q;
                state_d = (op == 4'hF) ? S_HALT : S_FETCH;
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            npc_q     <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            wb_q      <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            npc_q     <= npc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            wb_q      <= wb_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    // Entries at or above NREGS are never written and stay zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (reg_we && (32'(rd) < NREGS)) begin
            regs_q[rd] <= wb_q;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign alu_out   = alu_q;
    assign flags     = flags_q;
    assign halted    = (state_q == S_HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Bench for multicycle_cpu_core: wait-state ROM model, fetch-address scoreboard, per-scenario end-state checks.
module tb_multicycle_cpu_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [7:0]  pc_out;
    logic [7:0]  alu_out;
    logic [3:0]  flags;
    logic        halted;
    logic        illegal;
    logic [2:0]  dbg_addr = 3'd0;
    logic [7:0]  dbg_data;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] rom [256];
    logic [15:0] junk = 16'h0;
    int          wait_cfg = 0;
    int          wcnt = 0;
    logic [7:0]  exp_q [$];

    multicycle_cpu_core #(.DATA_W(8), .NREGS(4), .PC_W(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .pc_out(pc_out), .alu_out(alu_out), .flags(flags),
        .halted(halted), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    assign imem_valid = imem_req && rst && (wcnt >= wait_cfg);
    assign imem_data  = imem_req ? rom[imem_addr] : junk;

    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (imem_req && imem_valid) wcnt <= 0;
        else if (imem_req) wcnt <= wcnt + 1;
    end

    always @(posedge clk) junk <= 16'($urandom);

    // Fetch scoreboard: the address must match the queue head through all wait cycles.
    always @(negedge clk) begin
        if (rst && imem_req) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL fetch_unexpected: addr=%0h, required no fetch", imem_addr);
            end else begin
                if (imem_addr !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL fetch_addr: got %0h, required %0h", imem_addr, exp_q[0]);
                end
                if (imem_valid) void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic run_until_halt(input int budget, output int cycles);
        cycles = 0;
        forever begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (halted) break;
            if (cycles >= budget) begin
                n_cmp++;
                n_fail++;
                $display("FAIL halt_timeout: no halt after %0d cycles", cycles);
                break;
            end
        end
    endtask

    task automatic read_reg(input logic [2:0] idx, output logic [7:0] val);
        dbg_addr = idx;
        #1 val = dbg_data;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        enter_reset();
        n_cmp += 6;
        if (pc_out !== 8'h00)  begin n_fail++; $display("FAIL rst_pc: got %0h, required 0", pc_out); end
        if (alu_out !== 8'h00) begin n_fail++; $display("FAIL rst_alu: got %0h, required 0", alu_out); end
        if (flags !== 4'h0)    begin n_fail++; $display("FAIL rst_flags: got %b, required 0000", flags); end
        if (halted !== 1'b0)   begin n_fail++; $display("FAIL rst_halted: got %b, required 0", halted); end
        if (illegal !== 1'b0)  begin n_fail++; $display("FAIL rst_illegal: got %b, required 0", illegal); end
        if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req: got %b, required 1", imem_req); end
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            n_cmp++;
            if (v !== 8'h00) begin n_fail++; $display("FAIL rst_reg%0d: got %0h, required 0", i, v); end
        end
    endtask

    task automatic test_add(input int wait_states);
        int cyc;
        logic [7:0] v;
        enter_reset();
        wait_cfg = wait_states;
        rom[0] = enc_i(4'h6, 3'd0, 8'd10);
        rom[1] = enc_i(4'h6, 3'd1, 8'd20);
        rom[2] = enc_r(4'h1, 3'd2, 3'd0, 3'd1);
        rom[3] = 16'hF000;
        for (int a = 0; a < 4; a++) exp_q.push_back(8'(a));
        release_reset();
        run_until_halt(200, cyc);
        read_reg(3'd2, v);
        n_cmp += 6;
        if (v !== 8'd30)       begin n_fail++; $display("FAIL add_r2: got %0d, required 30", v); end
        if (flags !== 4'b0000) begin n_fail++; $display("FAIL add_flags: got %b, required 0000", flags); end
        if (alu_out !== 8'd30) begin n_fail++; $display("FAIL add_alu: got %0d, required 30", alu_out); end
        if (pc_out !== 8'd3)   begin n_fail++; $display("FAIL add_pc: got %0d, required 3", pc_out); end
        if (cyc !== 4 * (4 + wait_states))
            begin n_fail++; $display("FAIL add_cycles: got %0d, required %0d", cyc, 4 * (4 + wait_states)); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL add_fetches: %0d left, required 0", exp_q.size()); end
        wait_cfg = 0;
    endtask

    task automatic test_carry();
        int cyc;
        logic [7:0] v;
        enter_reset();
        rom[0] = enc_i(4'h6, 3'd0, 8'd200);
        rom[1] = enc_i(4'h6, 3'd1, 8'd100);
        rom[2] = enc_r(4'h1, 3'd2, 3'd0, 3'd1);
        for (int a = 0; a < 4; a++) exp_q.push_back(8'(a));
        release_reset();
        run_until_halt(200, cyc);
        read_reg(3'd2, v);
        n_cmp += 3;
        if (alu_out !== 8'd44) begin n_fail++; $display("FAIL carry_alu: got %0d, required 44", alu_out); end
        if (flags !== 4'b0001) begin n_fail++; $display("FAIL carry_flags: got %b, required 0001", flags); end
        if (v !== 8'd44)       begin n_fail++; $display("FAIL carry_r2: got %0d, required 44", v); end
        // Second program writes back into its own source register.
        enter_reset();
        rom[0] = enc_i(4'h6, 3'd0, 8'd100);
        rom[1] = enc_i(4'h6, 3'd1, 8'd100);
        rom[2] = enc_r(4'h1, 3'd0, 3'd0, 3'd1);
        for (int a = 0; a < 4; a++) exp_q.push_back(8'(a));
        release_reset();
        run_until_halt(200, cyc);
        read_reg(3'd0, v);
        n_cmp += 3;
        if (alu_out !== 8'd200) begin n_fail++; $display("FAIL ovf_alu: got %0d, required 200", alu_out); end
        if (flags !== 4'b1100)  begin n_fail++; $display("FAIL ovf_flags: got %b, required 1100", flags); end
        if (v !== 8'd200)       begin n_fail++; $display("FAIL ovf_r0: got %0d, required 200", v); end
    endtask

    task automatic test_branch(input logic [7:0] r1val);
        int cyc;
        logic       taken;
        logic [7:0] exp_pc;
        logic [3:0] exp_fl;
        taken  = (r1val == 8'd7);
        exp_pc = taken ? 8'h10 : 8'h04;
        exp_fl = taken ? 4'b0010 : 4'b0101;
        enter_reset();
        rom[0] = enc_i(4'h6, 3'd0, 8'd7);
        rom[1] = enc_i(4'h6, 3'd1, r1val);
        rom[2] = enc_r(4'hA, 3'd0, 3'd0, 3'd1);
        rom[3] = enc_i(4'h9, 3'd0, 8'h10);
        for (int a = 0; a < 4; a++) exp_q.push_back(8'(a));
        exp_q.push_back(exp_pc);
        release_reset();
        run_until_halt(200, cyc);
        n_cmp += 3;
        if (pc_out !== exp_pc) begin n_fail++; $display("FAIL br_pc: got %0h, required %0h", pc_out, exp_pc); end
        if (flags !== exp_fl)  begin n_fail++; $display("FAIL br_flags: got %b, required %b", flags, exp_fl); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL br_fetches: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_logic();
        int cyc;
        logic [7:0] v;
        logic [7:0] exp_r [8];
        enter_reset();
        rom[0] = enc_i(4'h6, 3'd5, 8'h55);
        rom[1] = enc_i(4'h6, 3'd0, 8'hF0);
        rom[2] = enc_i(4'h6, 3'd1, 8'h3C);
        rom[3] = enc_r(4'h2, 3'd2, 3'd0, 3'd1);
        rom[4] = enc_r(4'h3, 3'd3, 3'd0, 3'd1);
        rom[5] = enc_r(4'h4, 3'd2, 3'd0, 3'd1);
        rom[6] = enc_r(4'h5, 3'd1, 3'd1, 3'd1);
        rom[7] = enc_r(4'h7, 3'd0, 3'd2, 3'd0);
        for (int a = 0; a < 9; a++) exp_q.push_back(8'(a));
        exp_r = '{8'hFC, 8'h00, 8'hFC, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00};
        release_reset();
        run_until_halt(300, cyc);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i), v);
            n_cmp++;
            if (v !== exp_r[i]) begin n_fail++; $display("FAIL logic_r%0d: got %0h, required %0h", i, v, exp_r[i]); end
        end
        n_cmp += 3;
        if (alu_out !== 8'h00) begin n_fail++; $display("FAIL logic_alu: got %0h, required 0", alu_out); end
        if (flags !== 4'b0010) begin n_fail++; $display("FAIL logic_flags: got %b, required 0010", flags); end
        if (pc_out !== 8'd8)   begin n_fail++; $display("FAIL logic_pc: got %0d, required 8", pc_out); end
    endtask

    task automatic test_wrap_illegal();
        int cyc;
        logic [7:0] v;
        logic [7:0] seq [9];
        enter_reset();
        rom[0]   = enc_i(4'h9, 3'd0, 8'h05);
        rom[1]   = enc_i(4'h6, 3'd1, 8'h42);
        rom[2]   = enc_r(4'hA, 3'd0, 3'd0, 3'd0);
        rom[3]   = enc_i(4'h8, 3'd0, 8'hFF);
        rom[255] = 16'h0000;
        rom[5]   = enc_r(4'hB, 3'd1, 3'd1, 3'd1);
        rom[6]   = 16'h0000;
        seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hFF, 8'h00, 8'h05, 8'h06, 8'h07};
        for (int i = 0; i < 9; i++) exp_q.push_back(seq[i]);
        release_reset();
        run_until_halt(300, cyc);
        read_reg(3'd1, v);
        n_cmp += 5;
        if (illegal !== 1'b1)  begin n_fail++; $display("FAIL ill_sticky: got %b, required 1", illegal); end
        if (v !== 8'h42)       begin n_fail++; $display("FAIL ill_r1: got %0h, required 42", v); end
        if (pc_out !== 8'd7)   begin n_fail++; $display("FAIL ill_pc: got %0d, required 7", pc_out); end
        if (flags !== 4'b0010) begin n_fail++; $display("FAIL ill_flags: got %b, required 0010", flags); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL ill_fetches: %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_midop();
        int cyc;
        logic [7:0] v;
        enter_reset();
        rom[0] = enc_i(4'h6, 3'd0, 8'd5);
        rom[1] = enc_i(4'h6, 3'd1, 8'd6);
        rom[2] = enc_r(4'h1, 3'd2, 3'd0, 3'd1);
        for (int a = 0; a < 3; a++) exp_q.push_back(8'(a));
        release_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        read_reg(3'd0, v);
        n_cmp += 6;
        if (pc_out !== 8'h00)  begin n_fail++; $display("FAIL mid_pc: got %0h, required 0", pc_out); end
        if (alu_out !== 8'h00) begin n_fail++; $display("FAIL mid_alu: got %0h, required 0", alu_out); end
        if (flags !== 4'h0)    begin n_fail++; $display("FAIL mid_flags: got %b, required 0000", flags); end
        if (halted !== 1'b0)   begin n_fail++; $display("FAIL mid_halted: got %b, required 0", halted); end
        if (v !== 8'h00)       begin n_fail++; $display("FAIL mid_r0: got %0h, required 0", v); end
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL mid_fetches: %0d left, required 0", exp_q.size()); end
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        exp_q.push_back(8'h00);
        release_reset();
        run_until_halt(100, cyc);
        read_reg(3'd2, v);
        n_cmp += 3;
        if (v !== 8'h00)      begin n_fail++; $display("FAIL mid_r2: got %0h, required 0", v); end
        if (pc_out !== 8'h00) begin n_fail++; $display("FAIL mid_restart_pc: got %0h, required 0", pc_out); end
        if (cyc !== 4)        begin n_fail++; $display("FAIL mid_restart_cycles: got %0d, required 4", cyc); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
        test_reset();
        test_add(0);
        test_carry();
        test_branch(8'd7);
        test_branch(8'd8);
        test_logic();
        test_add(3);
        test_wrap_illegal();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
